syscall_controller: RTL and testbench

SYSCALL_CONTROLLER -- requirements
Module: syscall_controller

---
 rtl/syscall_controller_pkg.sv | 35 +++
 rtl/syscall_controller_sat_counter.sv | 32 +++
 rtl/syscall_controller.sv | 147 ++++++++++++++
 tb/tb_syscall_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/syscall_controller_pkg.sv
// Shared definitions for the syscall controller: syscall codes, the decode
// categories and the controller FSM state encoding.
package syscall_controller_pkg;

  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
  localparam logic [5:0]  FUNCT_SYSCALL  = 6'hc;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_DISPATCH,
    ST_PRINT,
    ST_DONE,
    ST_HALTED
  } state_e;

  typedef enum logic [1:0] {
    K_PRINT_INT,
    K_PRINT_CHAR,
    K_EXIT,
    K_BAD
  } sys_kind_e;

  function automatic sys_kind_e decode_code(input logic [31:0] code);
    case (code)
      SYS_PRINT_INT:  return K_PRINT_INT;
      SYS_PRINT_CHAR: return K_PRINT_CHAR;
      SYS_EXIT:       return K_EXIT;
      default:        return K_BAD;
    endcase
  endfunction

endpackage

// File: rtl/syscall_controller_sat_counter.sv
// Saturating up-counter with enable and synchronous clear; sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    count_d = count_q;
    if (en && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clear) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/syscall_controller.sv
// Syscall service controller: stalls the front end, lets pending register
// writes drain, then prints, exits or flags the syscall; keeps run counters.
module syscall_controller
  import syscall_controller_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        syscall_valid,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  input  logic        instr_retire,
  output logic        stall,
  output logic        console_valid,
  output logic [31:0] console_data,
  output logic        console_is_char,
  input  logic        console_ready,
  output logic        syscall_done,
  output logic        bad_syscall,
  output logic        halt,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
);

  state_e      state_q, state_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;
  logic [31:0] v0_q, v0_d;
  logic [31:0] a0_q, a0_d;
  logic [31:0] data_q, data_d;
  logic        is_char_q, is_char_d;
  logic        bad_q, bad_d;
  logic [31:0] v0_cap, a0_cap;
  logic        running;

  // The second DISPATCH cycle of a bad code works from the captured copies.
  assign v0_cap = bad_q ? v0_q : v0;
  assign a0_cap = bad_q ? a0_q : a0;

  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    v0_d          = v0_q;
    a0_d          = a0_q;
    data_d        = data_q;
    is_char_d     = is_char_q;
    bad_d         = 1'b0;
    stall         = 1'b0;
    console_valid = 1'b0;
    syscall_done  = 1'b0;
    halt          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (syscall_valid) begin
          stall       = 1'b1;
          drain_cnt_d = 4'(DRAIN_CYCLES - 1);
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        stall = 1'b1;
        if (drain_cnt_q == 4'd0) state_d = ST_DISPATCH;
        else                     drain_cnt_d = drain_cnt_q - 4'd1;
      end
      ST_DISPATCH: begin
        stall = 1'b1;
        v0_d  = v0_cap;
        a0_d  = a0_cap;
        case (decode_code(v0_cap))
          K_PRINT_INT: begin
            data_d    = a0_cap;
            is_char_d = 1'b0;
            state_d   = ST_PRINT;
          end
          K_PRINT_CHAR: begin
            data_d    = {24'b0, a0_cap[7:0]};
            is_char_d = 1'b1;
            state_d   = ST_PRINT;
          end
          K_EXIT:  state_d = ST_HALTED;
          default: begin
            // Hold one extra cycle so the error pulse precedes the done pulse.
            if (bad_q) state_d = ST_DONE;
            else       bad_d   = 1'b1;
          end
        endcase
      end
      ST_PRINT: begin
        stall         = 1'b1;
        console_valid = 1'b1;
        if (console_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        syscall_done = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_HALTED: begin
        stall = 1'b1;
        halt  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= 4'd0;
      v0_q        <= 32'd0;
      a0_q        <= 32'd0;
      data_q      <= 32'd0;
      is_char_q   <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      v0_q        <= v0_d;
      a0_q        <= a0_d;
      data_q      <= data_d;
      is_char_q   <= is_char_d;
      bad_q       <= bad_d;
    end
  end

  assign console_data    = data_q;
  assign console_is_char = is_char_q;
  assign bad_syscall     = bad_q;

  // Counters stop on the edge that enters HALTED is still counted.
  assign running = (state_q != ST_HALTED);

  sat_counter #(.WIDTH(32)) u_cycle_count (
    .clk   (clk),
    .clear (reset),
    .en    (running),
    .count (cycle_count)
  );

  sat_counter #(.WIDTH(32)) u_instr_count (
    .clk   (clk),
    .clear (reset),
    .en    (running && instr_retire),
    .count (instr_count)
  );

endmodule

// File: tb/tb_syscall_controller.sv
// Directed self-checking bench for syscall_controller with hand-derived
// cycle-by-cycle expectations, plus a narrow sat_counter for saturation.
module tb_syscall_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        syscall_valid;
  logic [31:0] v0, a0;
  logic        instr_retire;
  logic        stall, console_valid, console_is_char, console_ready;
  logic [31:0] console_data;
  logic        syscall_done, bad_syscall, halt;
  logic [31:0] cycle_count, instr_count;

  logic        sc_clr, sc_en;
  logic [3:0]  sc_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  syscall_controller #(.DRAIN_CYCLES(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .syscall_valid   (syscall_valid),
    .v0              (v0),
    .a0              (a0),
    .instr_retire    (instr_retire),
    .stall           (stall),
    .console_valid   (console_valid),
    .console_data    (console_data),
    .console_is_char (console_is_char),
    .console_ready   (console_ready),
    .syscall_done    (syscall_done),
    .bad_syscall     (bad_syscall),
    .halt            (halt),
    .cycle_count     (cycle_count),
    .instr_count     (instr_count)
  );

  sat_counter #(.WIDTH(4)) u_sc (
    .clk   (clk),
    .clear (sc_clr),
    .en    (sc_en),
    .count (sc_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_cv"},    32'(console_valid), 32'd0);
    check({tag, "_data"},  console_data, 32'd0);
    check({tag, "_char"},  32'(console_is_char), 32'd0);
    check({tag, "_done"},  32'(syscall_done), 32'd0);
    check({tag, "_bad"},   32'(bad_syscall), 32'd0);
    check({tag, "_halt"},  32'(halt), 32'd0);
    check({tag, "_cyc"},   cycle_count, 32'd0);
    check({tag, "_ins"},   instr_count, 32'd0);
  endtask

  initial begin
    reset = 1'b1; syscall_valid = 1'b0; v0 = '0; a0 = '0;
    instr_retire = 1'b0; console_ready = 1'b0; sc_clr = 1'b1; sc_en = 1'b0;
    tick(); tick();
    #1 check_all_zero("reset");
    reset = 1'b0; sc_clr = 1'b0;

    // print_int 42, ready high: valid at c0, print at c5, done at c6
    console_ready = 1'b1; v0 = 32'd1; a0 = 32'd42; syscall_valid = 1'b1;
    #1 check("t1_stall_c0", 32'(stall), 32'd1);
    for (int c = 1; c <= 7; c++) begin
      tick();
      syscall_valid = 1'b0;
      #1;
      check($sformatf("t1_stall_c%0d", c), 32'(stall), 32'(c <= 5));
      check($sformatf("t1_cv_c%0d", c),    32'(console_valid), 32'(c == 5));
      check($sformatf("t1_done_c%0d", c),  32'(syscall_done), 32'(c == 6));
      if (c == 5) begin
        check("t1_data", console_data, 32'd42);
        check("t1_char", 32'(console_is_char), 32'd0);
      end
    end

    // print_char with ready low for 4 PRINT cycles; a0 disturbed mid-print
    console_ready = 1'b0; v0 = 32'd11; a0 = 32'h1234_5641; syscall_valid = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      syscall_valid = 1'b0;
      if (c == 6) a0 = 32'd0;
      if (c == 9) console_ready = 1'b1;
      #1;
      check($sformatf("t2_cv_c%0d", c),   32'(console_valid), 32'(c >= 5 && c <= 9));
      check($sformatf("t2_done_c%0d", c), 32'(syscall_done), 32'(c == 10));
      if (c >= 5 && c <= 9) begin
        check($sformatf("t2_data_c%0d", c), console_data, 32'h41);
        check($sformatf("t2_char_c%0d", c), 32'(console_is_char), 32'd1);
      end
    end

    // unsupported code 7: bad pulse at c5, done at c6, no console traffic
    v0 = 32'd7; a0 = 32'd3; syscall_valid = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      syscall_valid = 1'b0;
      #1;
      check($sformatf("t3_bad_c%0d", c),   32'(bad_syscall), 32'(c == 5));
      check($sformatf("t3_done_c%0d", c),  32'(syscall_done), 32'(c == 6));
      check($sformatf("t3_cv_c%0d", c),    32'(console_valid), 32'd0);
      check($sformatf("t3_stall_c%0d", c), 32'(stall), 32'(c <= 5));
    end

    // repeated valid and changing v0/a0 during DRAIN; valid during DONE ignored
    v0 = 32'd5; a0 = 32'd0; syscall_valid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      case (c)
        1: begin v0 = 32'd11; a0 = 32'd99; end
        2: begin syscall_valid = 1'b0; v0 = 32'd1; a0 = 32'd77; end
        3: a0 = 32'd55;
        4: begin v0 = 32'd1; a0 = 32'd1234; end
        5: begin v0 = 32'd10; a0 = 32'd8; end
        6: syscall_valid = 1'b1;
        7: syscall_valid = 1'b0;
        default: ;
      endcase
      #1;
      if (c == 5) begin
        check("t4_cv", 32'(console_valid), 32'd1);
        check("t4_data", console_data, 32'd1234);
        check("t4_char", 32'(console_is_char), 32'd0);
      end
      if (c == 6) check("t4_done", 32'(syscall_done), 32'd1);
      if (c >= 7) check($sformatf("t4_idle_stall_c%0d", c), 32'(stall), 32'd0);
    end

    // reset while PRINT waits on ready
    console_ready = 1'b0; v0 = 32'd1; a0 = 32'd5; syscall_valid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      syscall_valid = 1'b0;
    end
    #1 check("t5_cv_before", 32'(console_valid), 32'd1);
    reset = 1'b1;
    tick();
    #1 check_all_zero("t5_after_reset");
    reset = 1'b0; console_ready = 1'b1; v0 = 32'd1; a0 = 32'd77; syscall_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      syscall_valid = 1'b0;
      #1;
      if (c == 5) check("t5_data", console_data, 32'd77);
      if (c == 6) check("t5_done", 32'(syscall_done), 32'd1);
    end

    // exit after 95 idle cycles (37 retires); counters freeze at 100/37
    reset = 1'b1;
    tick();
    reset = 1'b0; instr_retire = 1'b1;
    for (int i = 0; i < 37; i++) tick();
    instr_retire = 1'b0;
    for (int i = 0; i < 58; i++) tick();
    #1;
    check("t6_cyc_pre", cycle_count, 32'd95);
    check("t6_ins_pre", instr_count, 32'd37);
    v0 = 32'd10; syscall_valid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      syscall_valid = 1'b0;
      #1;
      if (c == 4) begin
        check("t6_halt_disp", 32'(halt), 32'd0);
        check("t6_cyc_disp", cycle_count, 32'd99);
      end
    end
    instr_retire = 1'b1; syscall_valid = 1'b1; v0 = 32'd1; console_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      check($sformatf("t6_halt_%0d", c),  32'(halt), 32'd1);
      check($sformatf("t6_stall_%0d", c), 32'(stall), 32'd1);
      check($sformatf("t6_cv_%0d", c),    32'(console_valid), 32'd0);
      check($sformatf("t6_cyc_%0d", c),   cycle_count, 32'd100);
      check($sformatf("t6_ins_%0d", c),   instr_count, 32'd37);
      tick();
    end
    syscall_valid = 1'b0; instr_retire = 1'b0; reset = 1'b1;
    tick();
    #1 check_all_zero("t6_reset_halt");
    reset = 1'b0;

    // narrow counter: counts to all-ones, saturates, clears
    sc_clr = 1'b1;
    tick();
    sc_clr = 1'b0; sc_en = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    #1 check("sc_14", 32'(sc_count), 32'd14);
    tick();
    #1 check("sc_15", 32'(sc_count), 32'd15);
    for (int i = 0; i < 5; i++) tick();
    #1 check("sc_sat", 32'(sc_count), 32'd15);
    sc_clr = 1'b1;
    tick();
    #1 check("sc_clr", 32'(sc_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
